// File: rtl/mem_stage.sv
// mem_stage: memory pipeline stage behind execute.
// Accepts one op per cycle when idle. ALU results go straight to writeback.
// Loads and stores run a req/ack handshake with the data cache, with a
// timeout, and stall upstream until the handshake finishes. Store byte
// lanes are built by one small lane slice per byte of the cache word.

// One byte lane of the store path: byte enable and replicated write byte.
module mem_st_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0]  i_size,   // 0 byte, 1 half, 2 word
    input  logic [1:0]  i_off,    // byte offset within the word
    input  logic [31:0] i_data,   // store data as supplied by execute
    output logic        o_strb,
    output logic [7:0]  o_byte
);
    localparam logic [1:0] LIDX = 2'(LANE);

    // Pick this lane's enable and source byte for the access size
    always_comb begin
        o_strb = 1'b0;
        o_byte = 8'h00;
        case (i_size)
            2'd0: begin
                o_strb = (i_off == LIDX);
                o_byte = i_data[7:0];
            end
            2'd1: begin
                o_strb = (i_off[1] == LIDX[1]);
                o_byte = i_data[8*(LANE%2) +: 8];
            end
            default: begin
                o_strb = 1'b1;
                o_byte = i_data[8*LANE +: 8];
            end
        endcase
    end
endmodule

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CACHE_READY,
    input  logic        EX_VALID,
    input  logic [31:0] WB_DATA_IN,
    input  logic [31:0] DATA_ADDRESS,
    input  logic [31:0] STORE_DATA,
    input  logic [1:0]  DATA_CACHE_CONTROL,
    input  logic [1:0]  TYPE_IN,
    input  logic        LOAD_UNSIGNED,
    input  logic [4:0]  RD_IN,
    output logic        DC_REQ,
    output logic        DC_WE,
    output logic [31:0] DC_ADDR,
    output logic [3:0]  DC_WSTRB,
    output logic [31:0] DC_WDATA,
    input  logic [31:0] DC_RDATA,
    input  logic        DC_ACK,
    output logic        WB_EN,
    output logic [4:0]  WB_RD,
    output logic [31:0] WB_DATA,
    output logic        MEM_STALLED,
    output logic        MISALIGNED,
    output logic        BUS_ERROR
);
    localparam int         NUM_LANES = 4;
    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_WAIT    = 1'b1;

    logic [0:0]           r_state;
    logic [CNT_WIDTH-1:0] r_cnt;

    // Attributes of the outstanding access, held for the whole WAIT
    logic [4:0]  r_rd;
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_uns;
    logic        r_ld;

    logic        r_dc_req;
    logic        r_dc_we;
    logic [31:0] r_dc_addr;
    logic [3:0]  r_dc_wstrb;
    logic [31:0] r_dc_wdata;
    logic        r_wb_en;
    logic [4:0]  r_wb_rd;
    logic [31:0] r_wb_data;
    logic        r_mis;
    logic        r_berr;

    logic [1:0]                w_size;
    logic                      w_is_load;
    logic                      w_is_store;
    logic                      w_misal;
    logic                      w_accept;
    logic [NUM_LANES-1:0]      w_strb;
    logic [NUM_LANES-1:0][7:0] w_wdata;
    logic [7:0]                w_lbyte;
    logic [15:0]               w_lhalf;
    logic [31:0]               w_load;

    // Type 11 behaves as a word access
    assign w_size     = (TYPE_IN == 2'b11) ? 2'b10 : TYPE_IN;
    assign w_is_load  = (DATA_CACHE_CONTROL == 2'b01);
    assign w_is_store = (DATA_CACHE_CONTROL == 2'b10);
    assign w_misal    = ((w_size == 2'd1) && DATA_ADDRESS[0]) ||
                        ((w_size == 2'd2) && (DATA_ADDRESS[1:0] != 2'b00));
    // Being stalled means WAIT, so this can only fire in IDLE
    assign w_accept   = EX_VALID && CACHE_READY && !MEM_STALLED;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            mem_st_lane #(.LANE(g)) u_lane (
                .i_size (w_size),
                .i_off  (DATA_ADDRESS[1:0]),
                .i_data (STORE_DATA),
                .o_strb (w_strb[g]),
                .o_byte (w_wdata[g])
            );
        end
    endgenerate

    // Extract the addressed lane of the read word and extend it
    always_comb begin
        w_lbyte = 8'h00;
        case (r_off)
            2'd0:    w_lbyte = DC_RDATA[7:0];
            2'd1:    w_lbyte = DC_RDATA[15:8];
            2'd2:    w_lbyte = DC_RDATA[23:16];
            default: w_lbyte = DC_RDATA[31:24];
        endcase
        w_lhalf = r_off[1] ? DC_RDATA[31:16] : DC_RDATA[15:0];
        case (r_size)
            2'd0:    w_load = {{24{!r_uns && w_lbyte[7]}}, w_lbyte};
            2'd1:    w_load = {{16{!r_uns && w_lhalf[15]}}, w_lhalf};
            default: w_load = DC_RDATA;
        endcase
    end

    // Stage state: accept, cache handshake, timeout and writeback registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_rd       <= 5'd0;
            r_off      <= 2'd0;
            r_size     <= 2'd0;
            r_uns      <= 1'b0;
            r_ld       <= 1'b0;
            r_dc_req   <= 1'b0;
            r_dc_we    <= 1'b0;
            r_dc_addr  <= 32'd0;
            r_dc_wstrb <= 4'd0;
            r_dc_wdata <= 32'd0;
            r_wb_en    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
            r_mis      <= 1'b0;
            r_berr     <= 1'b0;
        end else begin
            r_wb_en <= 1'b0;
            r_mis   <= 1'b0;
            r_berr  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!(w_is_load || w_is_store)) begin
                            r_wb_en   <= (RD_IN != 5'd0);
                            r_wb_rd   <= RD_IN;
                            r_wb_data <= WB_DATA_IN;
                        end else if (w_misal) begin
                            r_mis <= 1'b1;
                        end else begin
                            r_state    <= S_WAIT;
                            r_cnt      <= '0;
                            r_dc_req   <= 1'b1;
                            r_dc_we    <= w_is_store;
                            r_dc_addr  <= {DATA_ADDRESS[31:2], 2'b00};
                            r_dc_wstrb <= w_is_store ? w_strb : 4'b0000;
                            r_dc_wdata <= w_is_store ? w_wdata : 32'd0;
                            r_rd       <= RD_IN;
                            r_off      <= DATA_ADDRESS[1:0];
                            r_size     <= w_size;
                            r_uns      <= LOAD_UNSIGNED;
                            r_ld       <= w_is_load;
                        end
                    end
                end
                default: begin
                    // An ack on the timeout boundary still completes the access
                    if (DC_ACK) begin
                        r_state  <= S_IDLE;
                        r_dc_req <= 1'b0;
                        if (r_ld) begin
                            r_wb_en   <= (r_rd != 5'd0);
                            r_wb_rd   <= r_rd;
                            r_wb_data <= w_load;
                        end
                    end else if (r_cnt == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                        r_state  <= S_IDLE;
                        r_dc_req <= 1'b0;
                        r_berr   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_WIDTH'(1);
                    end
                end
            endcase
        end
    end

    assign MEM_STALLED = (r_state == S_WAIT);
    assign DC_REQ      = r_dc_req;
    assign DC_WE       = r_dc_we;
    assign DC_ADDR     = r_dc_addr;
    assign DC_WSTRB    = r_dc_wstrb;
    assign DC_WDATA    = r_dc_wdata;
    assign WB_EN       = r_wb_en;
    assign WB_RD       = r_wb_rd;
    assign WB_DATA     = r_wb_data;
    assign MISALIGNED  = r_mis;
    assign BUS_ERROR   = r_berr;
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly downstream of the execute stage.
- Consumes the execute stage's result, effective address, cache control and access-type outputs.
- Performs data-cache load/store handshakes with byte-lane alignment, and sign/zero extension of loaded data.
- Produces the registered register-file writeback and stalls upstream while a cache access is outstanding.

Parameters:
TIMEOUT_CYCLES, 255, cycles spent in WAIT without DC_ACK before the access is abandoned with BUS_ERROR
CNT_WIDTH, 8, width of the wait counter; must hold TIMEOUT_CYCLES

Ports:
CLK  in  1  clock, all state on rising edge
RST  in  1  synchronous reset, active-high
CACHE_READY  in  1  global cache-ready; low blocks acceptance of new ops
EX_VALID  in  1  execute-stage output valid this cycle
WB_DATA_IN  in  32  ALU result from execute stage
DATA_ADDRESS  in  32  effective byte address
STORE_DATA  in  32  rs2 value for stores
DATA_CACHE_CONTROL  in  2  00 none, 01 load, 10 store, 11 treated as none
TYPE_IN  in  2  00 byte, 01 half, 10 word, 11 treated as word
LOAD_UNSIGNED  in  1  1 = zero-extend byte/half loads
RD_IN  in  5  destination register
DC_REQ  out  1  cache request, held until DC_ACK sampled
DC_WE  out  1  1 = write
DC_ADDR  out  32  word-aligned address ({DATA_ADDRESS[31:2],2'b00})
DC_WSTRB  out  4  byte enables
DC_WDATA  out  32  lane-replicated store data
DC_RDATA  in  32  read data, valid with DC_ACK
DC_ACK  in  1  cache completion, one-cycle pulse
WB_EN  out  1  register write enable
WB_RD  out  5  writeback register
WB_DATA  out  32  writeback value
MEM_STALLED  out  1  upstream must hold its outputs
MISALIGNED  out  1  one-cycle pulse, misaligned access dropped
BUS_ERROR  out  1  one-cycle pulse, access timed out

Behaviour:
- Reset: all outputs 0, state IDLE, counter 0. Reset mid-WAIT drops DC_REQ on the next cycle with no writeback; a DC_ACK arriving in IDLE is ignored.
- Accept condition, evaluated in IDLE: EX_VALID & CACHE_READY & !MEM_STALLED.
- FSM states: IDLE and WAIT. MEM_STALLED = (state==WAIT).
- Non-memory op (control 00/11) accepted at edge T:
  - From T+1: WB_EN=(RD_IN!=0), WB_RD=RD_IN, WB_DATA=WB_DATA_IN.
  - Latency 1; back-to-back ops sustain one per cycle.
- No accept in a cycle: WB_EN=0 next cycle; WB_RD and WB_DATA hold.
- Memory op accepted:
  - Check alignment: half requires addr[0]=0; word requires addr[1:0]=00.
  - Misaligned: stay IDLE, MISALIGNED=1 for one cycle, WB_EN=0, no DC_REQ.
  - Aligned: register DC_* outputs, go to WAIT, counter cleared. DC_REQ=1 from the next cycle.
- Store lanes:
  - Byte: DC_WDATA={4{STORE_DATA[7:0]}}, DC_WSTRB=4'b0001<<addr[1:0].
  - Half: DC_WDATA={2{STORE_DATA[15:0]}}, DC_WSTRB=addr[1]?1100:0011.
  - Word: DC_WDATA=STORE_DATA, DC_WSTRB=1111.
- Loads: DC_WE=0, DC_WSTRB=0000.
- WAIT, DC_ACK=1:
  - Next cycle: IDLE, DC_REQ=0.
  - Load: WB_EN=(rd!=0), WB_DATA = extracted lane. Byte lane is rdata[8*addr[1:0]+:8]; half lane is rdata[16*addr[1]+:16].
  - Extension: sign-extended unless LOAD_UNSIGNED; word loads pass unchanged.
  - Store: WB_EN=0.
  - Minimum load latency: accept edge to WB_EN is 2 cycles.
- WAIT, no ACK: counter increments. When counter==TIMEOUT_CYCLES-1 without ACK: next cycle IDLE, DC_REQ=0, BUS_ERROR=1 for one cycle, WB_EN=0. ACK in the same cycle as the timeout boundary takes priority over timeout.
- CACHE_READY low:
  - Blocks acceptance only.
  - WAIT continues to observe DC_ACK and the timeout.
- Stalled inputs are not sampled; upstream must hold them stable.
- Captured rd, address offset, type and LOAD_UNSIGNED are held in internal registers for the duration of WAIT.

Test Plan:
- ALU op: WB_DATA_IN=0x1234, rd=5, control 00 -> next cycle WB_EN=1, WB_RD=5, WB_DATA=0x1234, MEM_STALLED=0; rd=0 -> WB_EN=0.
- Load byte signed: addr=0x103, DC_RDATA=0x80AABBCC, ACK 3 cycles after DC_REQ rises -> DC_ADDR=0x100, MEM_STALLED=1 for 4 cycles, WB_DATA=0xFFFFFF80. Same with LOAD_UNSIGNED=1 -> 0x00000080.
- Store half: addr=0x202, STORE_DATA=0xDEADBEEF -> DC_WE=1, DC_WSTRB=1100, DC_WDATA=0xBEEFBEEF, DC_ADDR=0x200; no WB_EN after ACK.
- Misaligned word load: addr=0x301 -> MISALIGNED pulse, DC_REQ never asserted, WB_EN=0, next op accepted the following cycle.
- Timeout: TIMEOUT_CYCLES=4, no ACK -> DC_REQ high exactly 4 cycles, then BUS_ERROR pulse, MEM_STALLED=0. Also: RST asserted in WAIT -> DC_REQ=0 next cycle, and a later stray ACK produces no WB_EN.
